// File: rtl/score_pkg.sv
// Shared types and constants for the scoreboard controller: button indices,
// two-digit BCD score type and the auto-repeat state encoding.
package score_pkg;

    localparam int BTN_A_INC = 0;
    localparam int BTN_A_DEC = 1;
    localparam int BTN_B_INC = 2;
    localparam int BTN_B_DEC = 3;

    typedef logic [7:0] bcd2_t;

    localparam bcd2_t SCORE_MAX = 8'h99;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-flop synchroniser, counting debouncer and a
// single-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= level_q;
            // Any sample that agrees with the current level restarts the count.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign press_o = level_q & ~prev_q;

endmodule

// File: rtl/score_ctrl.sv
// Scoreboard controller: debounced buttons drive two saturating BCD scores.
// Optional per-button auto-repeat is enabled by defining SCORE_AUTOREPEAT_EN.
module score_ctrl
    import score_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 20_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  btn,
    output logic [15:0] num,
    output logic        score_evt
);
    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_cfg_err
        $error("score_ctrl: cycle parameters out of range");
    end

    logic [3:0]  lvl;
    logic [3:0]  press;
    logic [3:0]  cmd;
    logic        all_hi_q;
    logic        clear;
    logic [15:0] num_q;
    logic [15:0] num_d;
    logic        evt_q;
    logic        evt_d;
    bcd2_t       a_d;
    bcd2_t       b_d;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_i   (btn[i]),
            .level_o (lvl[i]),
            .press_o (press[i])
        );
    end

    // Clear fires only on the cycle the fourth button joins the other three.
    assign clear = (&lvl) & ~all_hi_q;

`ifdef SCORE_AUTOREPEAT_EN
    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW   = $clog2(RMAX + 1);

    rpt_state_t    rpt_q [4];
    logic [RW-1:0] rcnt_q [4];
    logic [3:0]    rep_q;

    // The press cycle counts as the first held cycle, so HOLD starts at 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rpt_q[i]  <= RPT_IDLE;
                rcnt_q[i] <= '0;
            end
            rep_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                rep_q[i] <= 1'b0;
                if (clear || !lvl[i]) begin
                    rpt_q[i]  <= RPT_IDLE;
                    rcnt_q[i] <= '0;
                end else begin
                    case (rpt_q[i])
                        RPT_IDLE: begin
                            if (press[i]) begin
                                rpt_q[i]  <= RPT_HOLD;
                                rcnt_q[i] <= RW'(1);
                            end
                        end
                        RPT_HOLD: begin
                            if (rcnt_q[i] == RW'(HOLD_CYCLES - 1)) begin
                                rpt_q[i]  <= RPT_REPEAT;
                                rcnt_q[i] <= '0;
                                rep_q[i]  <= 1'b1;
                            end else begin
                                rcnt_q[i] <= rcnt_q[i] + 1'b1;
                            end
                        end
                        RPT_REPEAT: begin
                            if (rcnt_q[i] == RW'(REPEAT_CYCLES - 1)) begin
                                rcnt_q[i] <= '0;
                                rep_q[i]  <= 1'b1;
                            end else begin
                                rcnt_q[i] <= rcnt_q[i] + 1'b1;
                            end
                        end
                        default: begin
                            rpt_q[i]  <= RPT_IDLE;
                            rcnt_q[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign cmd = press | rep_q;
`else
    assign cmd = press;
`endif

    function automatic bcd2_t bcd_inc(input bcd2_t x);
        if (x == SCORE_MAX)      return x;
        else if (x[3:0] == 4'h9) return {x[7:4] + 4'd1, 4'h0};
        else                     return {x[7:4], x[3:0] + 4'd1};
    endfunction

    function automatic bcd2_t bcd_dec(input bcd2_t x);
        if (x == 8'h00)          return x;
        else if (x[3:0] == 4'h0) return {x[7:4] - 4'd1, 4'h9};
        else                     return {x[7:4], x[3:0] - 4'd1};
    endfunction

    always_comb begin
        a_d = num_q[15:8];
        b_d = num_q[7:0];
        if (clear) begin
            a_d = 8'h00;
            b_d = 8'h00;
        end else begin
            if (cmd[BTN_A_INC] && !cmd[BTN_A_DEC])      a_d = bcd_inc(num_q[15:8]);
            else if (cmd[BTN_A_DEC] && !cmd[BTN_A_INC]) a_d = bcd_dec(num_q[15:8]);
            if (cmd[BTN_B_INC] && !cmd[BTN_B_DEC])      b_d = bcd_inc(num_q[7:0]);
            else if (cmd[BTN_B_DEC] && !cmd[BTN_B_INC]) b_d = bcd_dec(num_q[7:0]);
        end
        num_d = {a_d, b_d};
        evt_d = (num_d != num_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            all_hi_q <= 1'b0;
            num_q    <= 16'h0000;
            evt_q    <= 1'b0;
        end else begin
            all_hi_q <= &lvl;
            num_q    <= num_d;
            evt_q    <= evt_d;
        end
    end

    assign num       = num_q;
    assign score_evt = evt_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl with short debounce/hold/repeat timings.
module tb_score_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  btn;
    logic [15:0] num;
    logic        score_evt;

    int n_cmp;
    int n_err;
    int evt_cnt;
    int e0;

    score_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (16),
        .REPEAT_CYCLES  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .num       (num),
        .score_evt (score_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n cycles, landing on a falling edge, counting score_evt pulses.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (score_evt === 1'b1) evt_cnt++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press(input int idx, input int times);
        repeat (times) begin
            btn[idx] = 1'b1;
            step(10);
            btn[idx] = 1'b0;
            step(10);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        step(cycles);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        evt_cnt = 0;
        rst_n   = 1'b0;
        btn     = 4'b0101;
        @(negedge clk);

        // Reset with A+1 and B+1 held through release
        step(3);
        check("reset_num", {16'h0, num}, 32'h0000);
        check("reset_evt", {31'h0, score_evt}, 32'h0);
        rst_n = 1'b1;
        e0 = evt_cnt;
        step(12);
        check("held_thru_reset_num", {16'h0, num}, 32'h0101);
        check("held_thru_reset_evt", evt_cnt - e0, 1);
        btn = 4'b0000;
        step(10);
        do_reset(2);
        check("reset_nonzero_num", {16'h0, num}, 32'h0000);

        // Bounce on A+1, then stable high
        e0 = evt_cnt;
        for (int k = 0; k < 10; k++) begin
            btn[0] = (k % 2 == 0);
            step(2);
        end
        check("bounce_no_change", {16'h0, num}, 32'h0000);
        btn[0] = 1'b1;
        step(6);
        check("bounce_t6_num", {16'h0, num}, 32'h0000);
        step(1);
        check("bounce_t7_num", {16'h0, num}, 32'h0100);
        check("bounce_t7_evt", {31'h0, score_evt}, 32'h1);
        step(10);
        btn[0] = 1'b0;
        step(10);
        check("bounce_single_evt", evt_cnt - e0, 1);

        // Carry, borrow and saturation
        do_reset(2);
        press(0, 10);
        check("carry_10", {16'h0, num}, 32'h1000);
        press(1, 1);
        check("borrow_09", {16'h0, num}, 32'h0900);
        press(0, 90);
        check("preload_99", {16'h0, num}, 32'h9900);
        e0 = evt_cnt;
        press(0, 1);
        check("sat_99_num", {16'h0, num}, 32'h9900);
        check("sat_99_evt", evt_cnt - e0, 0);
        press(3, 1);
        check("sat_00_num", {16'h0, num}, 32'h9900);
        check("sat_00_evt", evt_cnt - e0, 0);

        // Simultaneous commands
        do_reset(2);
        press(0, 5);
        check("preload_05", {16'h0, num}, 32'h0500);
        e0 = evt_cnt;
        btn = 4'b0011;
        step(10);
        btn = 4'b0000;
        step(10);
        check("cancel_num", {16'h0, num}, 32'h0500);
        check("cancel_evt", evt_cnt - e0, 0);
        btn = 4'b0101;
        step(10);
        btn = 4'b0000;
        step(10);
        check("both_teams_num", {16'h0, num}, 32'h0601);
        check("both_teams_evt", evt_cnt - e0, 1);

        // Clear
        press(0, 6);
        press(2, 33);
        check("preload_1234", {16'h0, num}, 32'h1234);
        e0 = evt_cnt;
        btn = 4'b1111;
        step(10);
        check("clear_num", {16'h0, num}, 32'h0000);
        check("clear_evt", evt_cnt - e0, 1);
        step(100);
        check("clear_hold_num", {16'h0, num}, 32'h0000);
        check("clear_hold_evt", evt_cnt - e0, 1);
        btn = 4'b0000;
        step(10);
        e0 = evt_cnt;
        btn = 4'b1111;
        step(10);
        btn = 4'b0000;
        step(10);
        check("clear_at_zero_evt", evt_cnt - e0, 0);
        check("clear_at_zero_num", {16'h0, num}, 32'h0000);

        // Long hold on B+1
        do_reset(2);
        e0 = evt_cnt;
        btn[2] = 1'b1;
`ifdef SCORE_AUTOREPEAT_EN
        step(7);
        check("rpt_press", {16'h0, num}, 32'h0001);
        step(15);
        check("rpt_before_hold", {16'h0, num}, 32'h0001);
        step(1);
        check("rpt_hold_16", {16'h0, num}, 32'h0002);
        step(8);
        check("rpt_24", {16'h0, num}, 32'h0003);
        step(8);
        check("rpt_32", {16'h0, num}, 32'h0004);
        btn[2] = 1'b0;
        step(20);
        check("rpt_stop_num", {16'h0, num}, 32'h0004);
        check("rpt_stop_evt", evt_cnt - e0, 4);
`else
        step(46);
        btn[2] = 1'b0;
        step(20);
        check("hold_single_num", {16'h0, num}, 32'h0001);
        check("hold_single_evt", evt_cnt - e0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
